// File: rtl/lab2_proc_pipe_hazard_ctrl.sv
// rtl/lab2_proc_pipe_hazard_ctrl.sv - TinyRV2 5-stage pipeline stall/squash/bypass controller
// Holds per-stage valid and decode bits; the datapath holds all data values.

module lab2_proc_pipe_hazard_ctrl #(
    parameter bit p_bypass_en = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imemresp_val_F,
    input  logic [23:0] decode_D,
    input  logic        br_taken_X,
    input  logic        dmemreq_rdy,
    input  logic        dmemresp_val,
    input  logic        proc2mngr_rdy,
    input  logic        imul_req_rdy_D,
    input  logic        imul_resp_val_X,
    output logic        reg_en_F,
    output logic        reg_en_D,
    output logic        reg_en_X,
    output logic        reg_en_M,
    output logic        reg_en_W,
    output logic [1:0]  pc_sel_F,
    output logic [1:0]  op1_byp_sel_D,
    output logic [1:0]  op2_byp_sel_D,
    output logic        imul_req_val_D,
    output logic        imul_resp_rdy_X,
    output logic        dmemreq_val,
    output logic        rf_wen_W,
    output logic [4:0]  rf_waddr_W,
    output logic        commit_W
);

    logic       w_rs1_en_D, w_rs2_en_D, w_rf_wen_D;
    logic [4:0] w_rs1_D, w_rs2_D, w_rd_D;
    logic       w_is_mem_D, w_is_load_D, w_is_mul_D, w_is_mngr_D;
    logic [1:0] w_jump_D;

    assign {w_rs1_en_D, w_rs1_D, w_rs2_en_D, w_rs2_D, w_rf_wen_D, w_rd_D,
            w_is_mem_D, w_is_load_D, w_is_mul_D, w_is_mngr_D, w_jump_D} = decode_D;

    logic       r_val_D, r_val_X, r_val_M, r_val_W;
    logic       r_wen_X, r_wen_M, r_wen_W;
    logic [4:0] r_rd_X, r_rd_M, r_rd_W;
    logic       r_mem_X, r_mem_M, r_load_X, r_mul_X;
    logic       r_mngr_X, r_mngr_M, r_mngr_W;
    logic [1:0] r_jump_X;

    function automatic logic f_match(input logic i_val, input logic i_wen, input logic [4:0] i_rd,
                                     input logic i_rs_en, input logic [4:0] i_rs);
        return i_val & i_wen & (i_rd != 5'd0) & i_rs_en & (i_rd == i_rs);
    endfunction

    logic w_m1_X, w_m1_M, w_m1_W, w_m2_X, w_m2_M, w_m2_W;
    assign w_m1_X = f_match(r_val_X, r_wen_X, r_rd_X, w_rs1_en_D, w_rs1_D);
    assign w_m1_M = f_match(r_val_M, r_wen_M, r_rd_M, w_rs1_en_D, w_rs1_D);
    assign w_m1_W = f_match(r_val_W, r_wen_W, r_rd_W, w_rs1_en_D, w_rs1_D);
    assign w_m2_X = f_match(r_val_X, r_wen_X, r_rd_X, w_rs2_en_D, w_rs2_D);
    assign w_m2_M = f_match(r_val_M, r_wen_M, r_rd_M, w_rs2_en_D, w_rs2_D);
    assign w_m2_W = f_match(r_val_W, r_wen_W, r_rd_W, w_rs2_en_D, w_rs2_D);

    logic w_load_use, w_raw_stall;
    assign w_load_use  = r_load_X & (w_m1_X | w_m2_X);
    assign w_raw_stall = !p_bypass_en & (w_m1_X | w_m1_M | w_m1_W | w_m2_X | w_m2_M | w_m2_W);

    logic w_ostall_D, w_ostall_X, w_ostall_M, w_ostall_W;
    logic w_stall_D, w_stall_X, w_stall_M, w_stall_W;
    assign w_ostall_W = r_val_W & r_mngr_W & !proc2mngr_rdy;
    assign w_ostall_M = r_val_M & r_mem_M & !dmemresp_val;
    assign w_ostall_X = r_val_X & ((r_mul_X & !imul_resp_val_X) | (r_mem_X & !dmemreq_rdy));
    assign w_ostall_D = r_val_D & (w_load_use | (w_is_mul_D & !imul_req_rdy_D) | w_raw_stall);

    assign w_stall_W = w_ostall_W;
    assign w_stall_M = w_ostall_M | w_stall_W;
    assign w_stall_X = w_ostall_X | w_stall_M;
    assign w_stall_D = w_ostall_D | w_stall_X;

    logic w_squash_X, w_squash_D;
    assign w_squash_X = r_val_X & !w_stall_X &
                        (((r_jump_X == 2'd3) & br_taken_X) | (r_jump_X == 2'd2));
    assign w_squash_D = r_val_D & !w_stall_D & (w_jump_D == 2'd1) & !w_squash_X;

    assign reg_en_F = !w_stall_D | w_squash_X;
    assign reg_en_D = !w_stall_D | w_squash_X;
    assign reg_en_X = !w_stall_X;
    assign reg_en_M = !w_stall_M;
    assign reg_en_W = !w_stall_W;

    // A redirect from X is older than one from D, so it wins.
    assign pc_sel_F = w_squash_X ? ((r_jump_X == 2'd2) ? 2'd3 : 2'd1) :
                      w_squash_D ? 2'd2 : 2'd0;

    assign op1_byp_sel_D = !p_bypass_en ? 2'd0 :
                           w_m1_X ? 2'd3 : w_m1_M ? 2'd2 : w_m1_W ? 2'd1 : 2'd0;
    assign op2_byp_sel_D = !p_bypass_en ? 2'd0 :
                           w_m2_X ? 2'd3 : w_m2_M ? 2'd2 : w_m2_W ? 2'd1 : 2'd0;

    // Any D-side stall other than the multiplier's own ready blocks the request,
    // so a stalled mul never hands the multiplier a second copy of its operands.
    assign imul_req_val_D  = r_val_D & w_is_mul_D & !w_squash_X & !w_stall_X &
                             !w_load_use & !w_raw_stall;
    assign imul_resp_rdy_X = r_val_X & r_mul_X & !w_stall_M;
    assign dmemreq_val     = r_val_X & r_mem_X & !w_stall_M;
    assign rf_wen_W        = r_val_W & r_wen_W & !w_stall_W;
    assign rf_waddr_W      = r_rd_W;
    assign commit_W        = r_val_W & !w_stall_W;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_val_D <= 1'b0;
            r_val_X <= 1'b0;
            r_val_M <= 1'b0;
            r_val_W <= 1'b0;
        end else begin
            if (reg_en_D) r_val_D <= imemresp_val_F & !w_squash_X & !w_squash_D;
            if (reg_en_X) r_val_X <= r_val_D & !w_stall_D & !w_squash_X;
            if (reg_en_M) r_val_M <= r_val_X & !w_stall_X;
            if (reg_en_W) r_val_W <= r_val_M & !w_stall_M;
        end
    end

    always_ff @(posedge clk) begin
        if (reg_en_X) begin
            r_wen_X  <= w_rf_wen_D;
            r_rd_X   <= w_rd_D;
            r_mem_X  <= w_is_mem_D;
            r_load_X <= w_is_load_D;
            r_mul_X  <= w_is_mul_D;
            r_mngr_X <= w_is_mngr_D;
            r_jump_X <= w_jump_D;
        end
        if (reg_en_M) begin
            r_wen_M  <= r_wen_X;
            r_rd_M   <= r_rd_X;
            r_mem_M  <= r_mem_X;
            r_mngr_M <= r_mngr_X;
        end
        if (reg_en_W) begin
            r_wen_W  <= r_wen_M;
            r_rd_W   <= r_rd_M;
            r_mngr_W <= r_mngr_M;
        end
    end

endmodule

// File: tb/tb_lab2_proc_pipe_hazard_ctrl.sv
// tb/tb_lab2_proc_pipe_hazard_ctrl.sv - scoreboard bench for the pipeline hazard controller
// A tiny fetch/decode model feeds instructions; retirements are checked against a queue.

module tb_lab2_proc_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        imemresp_val_F;
    logic [23:0] decode_D;
    logic        br_taken_X, dmemreq_rdy, dmemresp_val, proc2mngr_rdy;
    logic        imul_req_rdy_D, imul_resp_val_X;

    logic       b_en_F, b_en_D, b_en_X, b_en_M, b_en_W;
    logic [1:0] b_pc_sel, b_op1, b_op2;
    logic       b_req, b_rsp_rdy, b_dreq, b_wen, b_commit;
    logic [4:0] b_waddr;
    logic       n_en_F, n_en_D, n_en_X, n_en_M, n_en_W;
    logic [1:0] n_pc_sel, n_op1, n_op2;
    logic       n_req, n_rsp_rdy, n_dreq, n_wen, n_commit;
    logic [4:0] n_waddr;

    always #5 clk = ~clk;

    lab2_proc_pipe_hazard_ctrl #(.p_bypass_en(1'b1)) dut (
        .clk(clk), .reset(reset), .imemresp_val_F(imemresp_val_F), .decode_D(decode_D),
        .br_taken_X(br_taken_X), .dmemreq_rdy(dmemreq_rdy), .dmemresp_val(dmemresp_val),
        .proc2mngr_rdy(proc2mngr_rdy), .imul_req_rdy_D(imul_req_rdy_D),
        .imul_resp_val_X(imul_resp_val_X),
        .reg_en_F(b_en_F), .reg_en_D(b_en_D), .reg_en_X(b_en_X), .reg_en_M(b_en_M),
        .reg_en_W(b_en_W), .pc_sel_F(b_pc_sel), .op1_byp_sel_D(b_op1), .op2_byp_sel_D(b_op2),
        .imul_req_val_D(b_req), .imul_resp_rdy_X(b_rsp_rdy), .dmemreq_val(b_dreq),
        .rf_wen_W(b_wen), .rf_waddr_W(b_waddr), .commit_W(b_commit)
    );

    lab2_proc_pipe_hazard_ctrl #(.p_bypass_en(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .imemresp_val_F(imemresp_val_F), .decode_D(decode_D),
        .br_taken_X(br_taken_X), .dmemreq_rdy(dmemreq_rdy), .dmemresp_val(dmemresp_val),
        .proc2mngr_rdy(proc2mngr_rdy), .imul_req_rdy_D(imul_req_rdy_D),
        .imul_resp_val_X(imul_resp_val_X),
        .reg_en_F(n_en_F), .reg_en_D(n_en_D), .reg_en_X(n_en_X), .reg_en_M(n_en_M),
        .reg_en_W(n_en_W), .pc_sel_F(n_pc_sel), .op1_byp_sel_D(n_op1), .op2_byp_sel_D(n_op2),
        .imul_req_val_D(n_req), .imul_resp_rdy_X(n_rsp_rdy), .dmemreq_val(n_dreq),
        .rf_wen_W(n_wen), .rf_waddr_W(n_waddr), .commit_W(n_commit)
    );

    // The fetch/decode model follows whichever controller is under test.
    logic       sel_nb;
    logic       s_en_F, s_en_D, s_en_X, s_en_M, s_en_W, s_req, s_wen, s_commit;
    logic [1:0] s_pc_sel, s_op1, s_op2;
    logic [4:0] s_waddr;
    assign {s_en_F, s_en_D, s_en_X, s_en_M, s_en_W} = sel_nb ?
           {n_en_F, n_en_D, n_en_X, n_en_M, n_en_W} : {b_en_F, b_en_D, b_en_X, b_en_M, b_en_W};
    assign s_pc_sel = sel_nb ? n_pc_sel : b_pc_sel;
    assign s_op1    = sel_nb ? n_op1    : b_op1;
    assign s_op2    = sel_nb ? n_op2    : b_op2;
    assign s_req    = sel_nb ? n_req    : b_req;
    assign s_wen    = sel_nb ? n_wen    : b_wen;
    assign s_waddr  = sel_nb ? n_waddr  : b_waddr;
    assign s_commit = sel_nb ? n_commit : b_commit;

    typedef struct packed { logic [23:0] dec; logic [7:0] tgt; } inst_t;
    typedef struct packed { logic wen; logic [4:0] rd; } exp_t;

    inst_t prog[$];
    exp_t  expq[$];
    int    commit_cyc[$];
    int    pc, d_idx, x_idx, cyc;
    int    cnt_req, cnt_xstall, cnt_dstall, cnt_allstall, cnt_byp, cnt_commit;
    int    n_pass = 0, n_total = 0;

    localparam logic [3:0] FL_NONE = 4'b0000, FL_LW = 4'b1100, FL_MUL = 4'b0010, FL_MNGR = 4'b0001;

    function automatic inst_t mk(input logic r1e, input logic [4:0] r1, input logic r2e,
                                 input logic [4:0] r2, input logic wen, input logic [4:0] rd,
                                 input logic [3:0] fl, input logic [1:0] jmp, input logic [7:0] tgt);
        inst_t i;
        i.dec = {r1e, r1, r2e, r2, wen, rd, fl, jmp};
        i.tgt = tgt;
        return i;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic add_inst(input inst_t i, input bit retires);
        exp_t e;
        prog.push_back(i);
        if (retires) begin
            e.wen = i.dec[11];
            e.rd  = i.dec[10:6];
            expq.push_back(e);
        end
    endtask

    task automatic start_test(input bit nb);
        sel_nb = nb;
        prog.delete(); expq.delete(); commit_cyc.delete();
        cnt_req = 0; cnt_xstall = 0; cnt_dstall = 0; cnt_allstall = 0; cnt_byp = 0; cnt_commit = 0;
    endtask

    task automatic apply();
        imemresp_val_F = (pc < prog.size());
        decode_D = (d_idx < prog.size()) ? prog[d_idx].dec : 24'd0;
    endtask

    // Called at the falling edge: retire check, statistics, then step the fetch model.
    task automatic adv();
        exp_t e;
        int npc, nd, nx;
        cyc++;
        if (s_commit) begin
            cnt_commit++;
            commit_cyc.push_back(cyc);
            if (expq.size() == 0) check("commit_extra", 1, 0);
            else begin
                e = expq.pop_front();
                check("commit_rd", s_waddr, e.rd);
                check("commit_wen", s_wen, e.wen);
            end
        end
        cnt_req += s_req;
        if (!s_en_X) cnt_xstall++;
        if (!s_en_D) cnt_dstall++;
        if (!(s_en_F | s_en_D | s_en_X | s_en_M | s_en_W | s_commit | s_wen)) cnt_allstall++;
        if (s_op1 != 2'd0 || s_op2 != 2'd0) cnt_byp++;
        if (reset) begin
            npc = 0; nd = 0; nx = 0;
        end else begin
            nx = s_en_X ? d_idx : x_idx;
            nd = s_en_D ? pc : d_idx;
            npc = pc;
            if (s_en_F) begin
                case (s_pc_sel)
                    2'd0:    npc = (pc < prog.size()) ? pc + 1 : pc;
                    2'd2:    npc = int'(prog[d_idx].tgt);
                    default: npc = int'(prog[x_idx].tgt);
                endcase
            end
        end
        @(posedge clk);
        #1;
        pc = npc; d_idx = nd; x_idx = nx;
        apply();
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            adv();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pc = 0; d_idx = 0; x_idx = 0;
        apply();
        run(2);
        reset = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int k = 0;
        while (expq.size() != 0 && k < budget) begin
            @(negedge clk);
            adv();
            k++;
        end
        check({"drain_", tag}, expq.size(), 0);
        run(4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; br_taken_X = 1'b0; dmemreq_rdy = 1'b1; dmemresp_val = 1'b1;
        proc2mngr_rdy = 1'b1; imul_req_rdy_D = 1'b1; imul_resp_val_X = 1'b1;
        cyc = 0; pc = 0; d_idx = 0; x_idx = 0;
        start_test(1'b0);
        apply();

        @(negedge clk);
        check("rst_reg_en", {b_en_F, b_en_D, b_en_X, b_en_M, b_en_W}, 5'b11111);
        check("rst_pc_sel", b_pc_sel, 0);
        check("rst_byp", {b_op1, b_op2}, 0);
        check("rst_hs", {b_req, b_rsp_rdy, b_dreq, b_wen, b_commit}, 0);
        adv();

        // addi x1; add x2,x1,x1; add x3,x2,x1 : full forwarding, no stalls
        start_test(1'b0);
        add_inst(mk(1, 0, 0, 0, 1, 1, FL_NONE, 0, 0), 1);
        add_inst(mk(1, 1, 1, 1, 1, 2, FL_NONE, 0, 0), 1);
        add_inst(mk(1, 2, 1, 1, 1, 3, FL_NONE, 0, 0), 1);
        do_reset();
        run(2);
        @(negedge clk);
        check("t1_op1_X", s_op1, 3);
        check("t1_op2_X", s_op2, 3);
        check("t1_en_D", s_en_D, 1);
        adv();
        @(negedge clk);
        check("t1_op1_prio_X", s_op1, 3);
        check("t1_op2_M", s_op2, 2);
        adv();
        drain("t1", 20);
        check("t1_dstall", cnt_dstall, 0);
        check("t1_ncommit", commit_cyc.size(), 3);
        if (commit_cyc.size() == 3) begin
            check("t1_back2back_a", commit_cyc[1] - commit_cyc[0], 1);
            check("t1_back2back_b", commit_cyc[2] - commit_cyc[1], 1);
        end

        // lw x3; add x4,x3,x0 : one load-use bubble, then M bypass
        start_test(1'b0);
        add_inst(mk(1, 0, 0, 0, 1, 3, FL_LW, 0, 0), 1);
        add_inst(mk(1, 3, 1, 0, 1, 4, FL_NONE, 0, 0), 1);
        do_reset();
        run(2);
        @(negedge clk);
        check("t2_en_D", s_en_D, 0);
        check("t2_en_F", s_en_F, 0);
        check("t2_en_X", s_en_X, 1);
        adv();
        @(negedge clk);
        check("t2_op1_M", s_op1, 2);
        check("t2_op2", s_op2, 0);
        check("t2_en_D_after", s_en_D, 1);
        adv();
        drain("t2", 20);
        check("t2_dstall", cnt_dstall, 1);

        // mul x5 with a 4-cycle multiplier response delay
        start_test(1'b0);
        add_inst(mk(1, 1, 1, 2, 1, 5, FL_MUL, 0, 0), 1);
        imul_resp_val_X = 1'b0;
        do_reset();
        run(6);
        imul_resp_val_X = 1'b1;
        drain("t3", 20);
        check("t3_xstall", cnt_xstall, 4);
        check("t3_req_pulses", cnt_req, 1);
        check("t3_commits", cnt_commit, 1);

        // no-bypass core: beq taken in X while a RAW-stalled lw sits in D
        start_test(1'b1);
        br_taken_X = 1'b1;
        add_inst(mk(1, 0, 0, 0, 1, 7, FL_NONE, 0, 0), 1);
        add_inst(mk(1, 0, 1, 0, 0, 0, FL_NONE, 3, 4), 1);
        add_inst(mk(1, 7, 0, 0, 1, 8, FL_LW, 0, 0), 0);
        add_inst(mk(1, 8, 1, 8, 1, 9, FL_NONE, 0, 0), 0);
        add_inst(mk(1, 0, 0, 0, 1, 10, FL_NONE, 0, 0), 1);
        do_reset();
        run(3);
        @(negedge clk);
        check("t4_pc_sel_br", s_pc_sel, 1);
        check("t4_en_D_squash", s_en_D, 1);
        check("t4_en_F_squash", s_en_F, 1);
        adv();
        @(negedge clk);
        check("t4_pc_sel_after", s_pc_sel, 0);
        adv();
        drain("t4", 20);
        check("t4_byp_zero", cnt_byp, 0);
        br_taken_X = 1'b0;

        // csrw in W with the manager sink not ready for 3 cycles
        start_test(1'b0);
        add_inst(mk(1, 1, 0, 0, 0, 0, FL_MNGR, 0, 0), 1);
        add_inst(mk(1, 0, 0, 0, 1, 11, FL_NONE, 0, 0), 1);
        add_inst(mk(1, 0, 0, 0, 1, 12, FL_NONE, 0, 0), 1);
        proc2mngr_rdy = 1'b0;
        do_reset();
        run(4);
        @(negedge clk);
        check("t5_en_W", s_en_W, 0);
        check("t5_en_F", s_en_F, 0);
        check("t5_commit", s_commit, 0);
        adv();
        run(2);
        proc2mngr_rdy = 1'b1;
        drain("t5", 20);
        check("t5_allstall", cnt_allstall, 3);
        check("t5_commits", cnt_commit, 3);

        // jal in D redirects fetch and kills the instruction behind it
        start_test(1'b0);
        add_inst(mk(0, 0, 0, 0, 1, 1, FL_NONE, 1, 2), 1);
        add_inst(mk(1, 0, 0, 0, 1, 13, FL_NONE, 0, 0), 0);
        add_inst(mk(1, 0, 0, 0, 1, 14, FL_NONE, 0, 0), 1);
        do_reset();
        run(1);
        @(negedge clk);
        check("t7_pc_sel_jal", s_pc_sel, 2);
        check("t7_en_F", s_en_F, 1);
        adv();
        drain("t7", 20);

        // no-bypass core: addi x1; add x2,x1 stalls until the producer leaves W
        start_test(1'b1);
        add_inst(mk(1, 0, 0, 0, 1, 1, FL_NONE, 0, 0), 1);
        add_inst(mk(1, 1, 1, 1, 1, 2, FL_NONE, 0, 0), 1);
        do_reset();
        drain("t6", 20);
        check("t6_dstall", cnt_dstall, 3);
        check("t6_byp_zero", cnt_byp, 0);

        // reset asserted in the middle of that stall drops everything in flight
        start_test(1'b1);
        add_inst(mk(1, 0, 0, 0, 1, 1, FL_NONE, 0, 0), 0);
        add_inst(mk(1, 1, 1, 1, 1, 2, FL_NONE, 0, 0), 0);
        do_reset();
        run(3);
        @(negedge clk);
        check("t6r_stalled", s_en_D, 0);
        reset = 1'b1;
        #1;
        check("t6r_reg_en", {s_en_F, s_en_D, s_en_X, s_en_M, s_en_W}, 5'b11111);
        check("t6r_hs", {n_req, n_rsp_rdy, n_dreq, n_wen, n_commit}, 0);
        adv();
        prog.delete();
        apply();
        run(1);
        reset = 1'b0;
        run(8);
        check("t6r_no_commit", cnt_commit, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
